// File: rtl/timer_pkg.sv
// timer_pkg: register map, control bits, opcodes and sequencer states for the interval-timer master
package timer_pkg;
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;
  localparam logic [2:0] OP_ILLEGAL       = 3'd0;
  localparam logic [2:0] OP_SET_PERIOD    = 3'd1;
  localparam logic [2:0] OP_START         = 3'd2;
  localparam logic [2:0] OP_STOP          = 3'd3;
  localparam logic [2:0] OP_SNAPSHOT      = 3'd4;
  localparam logic [2:0] OP_STATUS        = 3'd5;
  localparam logic [2:0] OP_CLEAR         = 3'd6;
  localparam logic [2:0] OP_SET_AND_START = 3'd7;
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WR_SNAP, RD_SL, RD_SH, RD_WAIT,
    RD_STAT, STAT_WAIT, WR_CLR, ACK_WR, ACK_WAIT, RESP
  } state_e;
endpackage

// File: rtl/timer_avalon_master.sv
// timer_avalon_master: turns single-beat commands into Avalon-MM access sequences on a 16-bit interval timer
// Ports: clk/reset_n (async, active-low); cmd_* command in (valid/ready/op/data);
// rsp_* response out (valid/ready/data/err); av_* timer s1 master; irq_in timer irq; tick_out per-timeout pulse.
module timer_avalon_master
  import timer_pkg::*;
#(
  parameter bit CONT_MODE = 1'b1,
  parameter bit IRQ_EN    = 1'b1,
  parameter bit AUTO_ACK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        irq_in,
  output logic        tick_out
);
  state_e state_q, state_d;
  logic [2:0] op_q, op, addr_q, addr_d;
  logic [31:0] pd_q, pd, cap_q, cap_d;
  logic [15:0] wd_q, wd_d;
  logic [3:0] ctrl;
  logic err_q, ready_q, rsp_valid_q, tick_q, cs_q, wn_q, cs_d, wn_d;
  logic irq_pend, accept, done;
  assign irq_pend  = AUTO_ACK && irq_in;
  // ready_q tracks IDLE but stays low through reset so nothing is accepted until the first edge after release
  assign cmd_ready = ready_q && !irq_pend;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == RESP) && rsp_ready;
  // bus registers are loaded from the next state, so the first access must see the command fields directly
  assign op = (state_q == IDLE) ? cmd_op : op_q;
  assign pd = (state_q == IDLE) ? cmd_data : pd_q;
  always_comb begin
    ctrl        = '0;
    ctrl[STOP]  = op == OP_STOP;
    ctrl[START] = op != OP_STOP;
    ctrl[CONT]  = CONT_MODE;
    ctrl[ITO]   = IRQ_EN;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (irq_pend) state_d = ACK_WR;
        else if (accept)
          case (cmd_op)
            OP_SET_PERIOD, OP_SET_AND_START: state_d = WR_PL;
            OP_START, OP_STOP:               state_d = WR_CTRL;
            OP_SNAPSHOT:                     state_d = WR_SNAP;
            OP_STATUS:                       state_d = RD_STAT;
            OP_CLEAR:                        state_d = WR_CLR;
            default:                         state_d = RESP;
          endcase
      end
      WR_PL:     state_d = WR_PH;
      WR_PH:     state_d = (op_q == OP_SET_AND_START) ? WR_CTRL : RESP;
      WR_CTRL:   state_d = RESP;
      WR_SNAP:   state_d = RD_SL;
      RD_SL:     state_d = RD_SH;
      RD_SH:     state_d = RD_WAIT;
      RD_WAIT:   state_d = RESP;
      RD_STAT:   state_d = STAT_WAIT;
      STAT_WAIT: state_d = RESP;
      WR_CLR:    state_d = RESP;
      ACK_WR:    state_d = ACK_WAIT;
      ACK_WAIT:  state_d = IDLE;
      RESP:      state_d = rsp_ready ? IDLE : RESP;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    cs_d   = !(state_d inside {IDLE, RD_WAIT, STAT_WAIT, ACK_WAIT, RESP});
    wn_d   = !(state_d inside {WR_PL, WR_PH, WR_CTRL, WR_SNAP, WR_CLR, ACK_WR});
    addr_d = (state_d == WR_PL) ? ADDR_PERIODL :
             (state_d == WR_PH) ? ADDR_PERIODH :
             (state_d == WR_CTRL) ? ADDR_CONTROL :
             (state_d inside {WR_SNAP, RD_SL}) ? ADDR_SNAPL :
             (state_d == RD_SH) ? ADDR_SNAPH : ADDR_STATUS;
    wd_d   = (state_d == WR_PL) ? pd[15:0] :
             (state_d == WR_PH) ? pd[31:16] :
             (state_d == WR_CTRL) ? {12'd0, ctrl} : 16'd0;
  end
  // read data arrives the cycle after each read address
  assign cap_d = (accept || done) ? 32'd0 :
                 (state_q == RD_SH) ? {cap_q[31:16], av_readdata} :
                 (state_q == RD_WAIT) ? {av_readdata, cap_q[15:0]} :
                 (state_q == STAT_WAIT) ? {30'd0, av_readdata[1:0]} : cap_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ILLEGAL;
      pd_q        <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      tick_q      <= 1'b0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= ADDR_STATUS;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= accept ? cmd_op : op_q;
      pd_q        <= accept ? cmd_data : pd_q;
      cap_q       <= cap_d;
      err_q       <= accept ? (cmd_op == OP_ILLEGAL) : (done ? 1'b0 : err_q);
      ready_q     <= state_d == IDLE;
      rsp_valid_q <= state_d == RESP;
      tick_q      <= state_d == ACK_WR;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
    end
  end
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = cap_q;
  assign rsp_err       = err_q;
  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wd_q;
  assign tick_out      = tick_q;
endmodule

// File: tb/tb_timer_avalon_master.sv
// tb_timer_avalon_master: directed bench with a small interval-timer slave model on the Avalon side
module tb_timer_avalon_master;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, tick_out;
  logic [2:0] cmd_op = 3'd0, av_address;
  logic [31:0] cmd_data = 32'd0, rsp_data;
  logic av_chipselect, av_write_n, irq_in;
  logic [15:0] av_writedata, av_readdata;
  logic irq_force = 1'b0, poke_req = 1'b0, poke_run = 1'b0;
  logic [31:0] poke_cnt = 32'd0;
  logic [31:0] m_per = 32'd0, m_cnt = 32'd0, m_snap = 32'd0;
  logic m_run = 1'b0, m_to = 1'b0;
  logic [3:0] m_ctrl = 4'd0;
  logic [15:0] m_rdata = 16'd0;
  int tests = 0, fails = 0;
  localparam logic [56:0] RST_V = {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0};
  localparam logic [21:0] IDLE_B = {1'b0, 1'b0, 1'b1, 3'd0, 16'h0};
  localparam logic [21:0] RSP_B = {1'b1, 1'b0, 1'b1, 3'd0, 16'h0};

  always #5 clk = ~clk;

  timer_avalon_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .av_address(av_address),
    .av_chipselect(av_chipselect), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .irq_in(irq_in), .tick_out(tick_out)
  );

  assign av_readdata = m_rdata;
  assign irq_in = (m_to && m_ctrl[0]) || irq_force;

  // timer slave model: read latency 1, period writes stop it, start strobe reloads
  always @(posedge clk) begin
    if (av_chipselect && av_write_n)
      case (av_address)
        3'd0: m_rdata <= {14'd0, m_run, m_to};
        3'd1: m_rdata <= {12'd0, m_ctrl};
        3'd2: m_rdata <= m_per[15:0];
        3'd3: m_rdata <= m_per[31:16];
        3'd4: m_rdata <= m_snap[15:0];
        3'd5: m_rdata <= m_snap[31:16];
        default: m_rdata <= 16'd0;
      endcase
    if (poke_req) begin
      m_cnt <= poke_cnt;
      m_run <= poke_run;
      m_to <= 1'b0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_to <= 1'b1;
          m_cnt <= m_per;
          m_run <= m_ctrl[1];
        end else m_cnt <= m_cnt - 32'd1;
      end
      if (av_chipselect && !av_write_n)
        case (av_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ctrl <= av_writedata[3:0];
            if (av_writedata[2]) begin
              m_run <= 1'b1;
              m_cnt <= m_per;
            end else if (av_writedata[3]) m_run <= 1'b0;
          end
          3'd2: begin m_per[15:0] <= av_writedata; m_run <= 1'b0; end
          3'd3: begin m_per[31:16] <= av_writedata; m_run <= 1'b0; end
          3'd4: m_snap <= m_cnt;
          default: ;
        endcase
    end
  end

  function automatic logic [21:0] bus_v();
    return {rsp_valid, av_chipselect, av_write_n, av_address, av_writedata};
  endfunction

  function automatic logic [56:0] out_v();
    return {cmd_ready, rsp_valid, rsp_data, rsp_err, av_chipselect, av_write_n, av_address, av_writedata, tick_out};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout op=%0d ready=%b required 1", op, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic poke(input logic [31:0] c, input logic r);
    @(negedge clk);
    poke_cnt = c; poke_run = r; poke_req = 1'b1;
    @(posedge clk);
    #1 poke_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (out_v() !== RST_V) begin fails++; $display("FAIL reset_values got %h required %h", out_v(), RST_V); end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b required 1", cmd_ready); end
  endtask

  task automatic test_set_period();
    logic [21:0] e [3];
    e = '{{1'b0, 1'b1, 1'b0, 3'd2, 16'hBB9F}, {1'b0, 1'b1, 1'b0, 3'd3, 16'h000D}, RSP_B};
    issue(3'd1, 32'h000DBB9F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus_v() !== e[i]) begin fails++; $display("FAIL set_period N+%0d got %h required %h", i, bus_v(), e[i]); end
    end
    tests++;
    if ({rsp_err, rsp_data} !== 33'd0) begin fails++; $display("FAIL set_period_rsp got %h required 0", {rsp_err, rsp_data}); end
    finish_rsp();
  endtask

  task automatic test_set_and_start();
    logic [21:0] e [3];
    int lows = 0, ticks = 0, acks = 0, post = 0;
    logic seen = 1'b0;
    e = '{{1'b0, 1'b1, 1'b0, 3'd2, 16'h0010}, {1'b0, 1'b1, 1'b0, 3'd3, 16'h0000}, {1'b0, 1'b1, 1'b0, 3'd1, 16'h0007}};
    issue(3'd7, 32'h00000010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus_v() !== e[i]) begin fails++; $display("FAIL set_and_start N+%0d got %h required %h", i, bus_v(), e[i]); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus_v() !== RSP_B) begin fails++; $display("FAIL set_and_start_rsp got %h required %h", bus_v(), RSP_B); end
    if (!irq_in) lows++;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 60 && post < 6; i++) begin
      @(negedge clk);
      if (irq_in) seen = 1'b1;
      else if (!seen) lows++;
      if (seen) post++;
      if (tick_out) ticks++;
      if (av_chipselect && !av_write_n && av_address == 3'd0) acks++;
    end
    tests++;
    if (lows != 17) begin fails++; $display("FAIL irq_delay got %0d required 17", lows); end
    tests++;
    if (ticks != 1) begin fails++; $display("FAIL tick_count got %0d required 1", ticks); end
    tests++;
    if (acks != 1) begin fails++; $display("FAIL ack_writes got %0d required 1", acks); end
    tests++;
    if (irq_in !== 1'b0) begin fails++; $display("FAIL irq_after_ack got %b required 0", irq_in); end
    issue(3'd3, 32'd0);
    @(negedge clk);
    tests++;
    if (bus_v() !== {1'b0, 1'b1, 1'b0, 3'd1, 16'h000B}) begin fails++; $display("FAIL stop_write got %h required %h", bus_v(), {1'b0, 1'b1, 1'b0, 3'd1, 16'h000B}); end
    @(negedge clk);
    tests++;
    if (bus_v() !== RSP_B) begin fails++; $display("FAIL stop_rsp got %h required %h", bus_v(), RSP_B); end
    finish_rsp();
  endtask

  task automatic test_snapshot();
    logic [21:0] e [5];
    e = '{{1'b0, 1'b1, 1'b0, 3'd4, 16'h0}, {1'b0, 1'b1, 1'b1, 3'd4, 16'h0}, {1'b0, 1'b1, 1'b1, 3'd5, 16'h0}, IDLE_B, RSP_B};
    poke(32'h00012345, 1'b0);
    issue(3'd4, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus_v() !== e[i]) begin fails++; $display("FAIL snapshot N+%0d got %h required %h", i, bus_v(), e[i]); end
    end
    tests++;
    if (rsp_data !== 32'h00012345) begin fails++; $display("FAIL snapshot_data got %h required 00012345", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_status_hold();
    logic [21:0] e [3];
    e = '{{1'b0, 1'b1, 1'b1, 3'd0, 16'h0}, IDLE_B, RSP_B};
    poke(32'h00001000, 1'b1);
    issue(3'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus_v() !== e[i]) begin fails++; $display("FAIL status N+%0d got %h required %h", i, bus_v(), e[i]); end
    end
    tests++;
    if (rsp_data !== 32'h2) begin fails++; $display("FAIL status_data got %h required 00000002", rsp_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_data} !== {1'b1, 32'h2}) begin fails++; $display("FAIL rsp_hold cyc %0d got %h required %h", i, {rsp_valid, rsp_data}, {1'b1, 32'h2}); end
    end
    finish_rsp();
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_drop got %b required 0", rsp_valid); end
    poke(32'd0, 1'b0);
  endtask

  task automatic test_irq_priority();
    logic [23:0] e [6];
    e = '{{1'b0, 1'b0, IDLE_B}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0}, {1'b0, 1'b0, IDLE_B},
          {1'b0, 1'b1, IDLE_B}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0}, {1'b0, 1'b0, RSP_B}};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_data = 32'd0; irq_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) #1;
      else @(negedge clk);
      tests++;
      if ({tick_out, cmd_ready, bus_v()} !== e[i]) begin fails++; $display("FAIL irq_priority cyc %0d got %h required %h", i, {tick_out, cmd_ready, bus_v()}, e[i]); end
      if (i == 0) begin @(posedge clk); #1 irq_force = 1'b0; end
      if (i == 3) begin @(posedge clk); #1 cmd_valid = 1'b0; end
    end
    finish_rsp();
  endtask

  task automatic test_illegal();
    issue(3'd0, 32'hFFFFFFFF);
    @(negedge clk);
    tests++;
    if ({rsp_err, rsp_data, bus_v()} !== {1'b1, 32'h0, RSP_B}) begin fails++; $display("FAIL illegal_op got %h required %h", {rsp_err, rsp_data, bus_v()}, {1'b1, 32'h0, RSP_B}); end
    finish_rsp();
    @(negedge clk);
    tests++;
    if ({rsp_err, rsp_valid} !== 2'b00) begin fails++; $display("FAIL illegal_clear got %b required 00", {rsp_err, rsp_valid}); end
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'd0);
    repeat (3) @(negedge clk);
    tests++;
    if (bus_v() !== {1'b0, 1'b1, 1'b1, 3'd5, 16'h0}) begin fails++; $display("FAIL rd_sh_bus got %h required %h", bus_v(), {1'b0, 1'b1, 1'b1, 3'd5, 16'h0}); end
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_v() !== RST_V) begin fails++; $display("FAIL reset_async got %h required %h", out_v(), RST_V); end
    @(negedge clk);
    tests++;
    if (out_v() !== RST_V) begin fails++; $display("FAIL reset_hold got %h required %h", out_v(), RST_V); end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({cmd_ready, bus_v()} !== {1'b1, IDLE_B}) begin fails++; $display("FAIL idle_after_reset got %h required %h", {cmd_ready, bus_v()}, {1'b1, IDLE_B}); end
    issue(3'd6, 32'd0);
    @(negedge clk);
    tests++;
    if (bus_v() !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h0}) begin fails++; $display("FAIL clear_write got %h required %h", bus_v(), {1'b0, 1'b1, 1'b0, 3'd0, 16'h0}); end
    @(negedge clk);
    tests++;
    if (bus_v() !== RSP_B) begin fails++; $display("FAIL clear_rsp got %h required %h", bus_v(), RSP_B); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_set_period();
    test_set_and_start();
    test_snapshot();
    test_status_hold();
    test_irq_priority();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
